// File: rtl/nibble_serial_sub.sv
// -----------------------------------------------------------------------------
// nibble_serial_sub
//
// Multi-cycle unsigned subtractor: res = a - b - bin over a 4*NIBBLES-bit word.
// One 4-bit nibble is processed per clock, least-significant nibble first, as
// a_n + ~b_n + c with the carry c held in a register between nibbles. Final
// borrow is the inverted carry out of the top nibble.
//
// Parameters:
//   NIBBLES  number of 4-bit nibbles (1..16), word width W = 4*NIBBLES
//
// Ports:
//   clk    in   1  sole clock, rising edge
//   rst    in   1  synchronous active-high reset, priority over start
//   start  in   1  request a new subtraction, sampled in IDLE and DONE
//   a      in   W  minuend, latched on an accepted start
//   b      in   W  subtrahend, latched on an accepted start
//   bin    in   1  borrow-in, latched on an accepted start
//   busy   out  1  high while nibbles are being processed (RUN)
//   done   out  1  one-cycle pulse, res/bout valid
//   res    out  W  difference modulo 2^W
//   bout   out  1  final borrow (a < b + bin)
//
// Build option:
//   NSUB_SATURATE_EN  when defined, res is forced to zero whenever the final
//                     borrow is set (unsigned floor saturation); bout still 1.
// -----------------------------------------------------------------------------
module nibble_serial_sub #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   res,
    output logic                   bout
);

    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIBBLES - 1);

    // One-hot so busy/done are each a direct decode of a single state flop.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic              accept_s;
    logic              last_s;
    logic [4:0]        slice_s;
    logic [3:0]        nib_a_s;
    logic [3:0]        nib_b_s;
    logic [W-1:0]      a_r;
    logic [W-1:0]      b_r;
    logic              c_r;
    logic [IDXW-1:0]   idx_r;
    logic [W-1:0]      res_r;
    logic              bout_r;
    logic              busy_s;
    logic              done_s;

    // 4-bit subtract slice: {carry_out, sum} = a_n + ~b_n + c.
    function automatic logic [4:0] nibble_sub_slice(
        input logic [3:0] a_n,
        input logic [3:0] b_n,
        input logic       c_in
    );
        return {1'b0, a_n} + {1'b0, ~b_n} + {4'b0000, c_in};
    endfunction

    // Current nibble selection and slice evaluation.
    always_comb begin
        nib_a_s = a_r[{idx_r, 2'b00} +: 4];
        nib_b_s = b_r[{idx_r, 2'b00} +: 4];
        slice_s = nibble_sub_slice(nib_a_s, nib_b_s, c_r);
        if (idx_r == IDX_LAST) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and start acceptance (IDLE or DONE only).
    always_comb begin
        state_nxt_s = ST_IDLE;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept_s    = 1'b1;
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_RUN: begin
                busy_s = 1'b1;
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Operand latch, carry chain, nibble index and result collection.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            c_r    <= 1'b0;
            idx_r  <= '0;
            res_r  <= '0;
            bout_r <= 1'b0;
        end else if (accept_s) begin
            // Carry-in is the inverse of the borrow-in (two's complement).
            a_r   <= a;
            b_r   <= b;
            c_r   <= ~bin;
            idx_r <= '0;
        end else if (state_r == ST_RUN) begin
            c_r <= slice_s[4];
            if (last_s) begin
                idx_r  <= '0;
                bout_r <= ~slice_s[4];
`ifdef NSUB_SATURATE_EN
                if (!slice_s[4]) begin
                    res_r <= '0;
                end else begin
                    res_r[{idx_r, 2'b00} +: 4] <= slice_s[3:0];
                end
`else
                res_r[{idx_r, 2'b00} +: 4] <= slice_s[3:0];
`endif
            end else begin
                idx_r <= idx_r + IDX_ONE;
                res_r[{idx_r, 2'b00} +: 4] <= slice_s[3:0];
            end
        end
    end

    assign busy = busy_s;
    assign done = done_s;
    assign res  = res_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_nibble_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_sub
//
// Directed, table-driven bench for nibble_serial_sub with NIBBLES=4. A table of
// hand-computed {a, b, bin, res, bout} records is applied one operation at a
// time; hand-written sequences cover reset, start during RUN, back-to-back
// start in DONE, and reset mid-operation.
// -----------------------------------------------------------------------------
module tb_nibble_serial_sub;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] res;
    logic         bout;

    int checks;
    int errors;

    nibble_serial_sub #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .res   (res),
        .bout  (bout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] res;
        logic         bout;
    } vec_t;

    vec_t vecs[10];

    // Expected result as seen on res, taking the saturation build into account.
    function automatic logic [W-1:0] exp_res(input logic [W-1:0] r, input logic bo);
`ifdef NSUB_SATURATE_EN
        return bo ? '0 : r;
`else
        return r;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Caller has driven start=1 and operands before a rising edge. Waits for
    // done with a cycle budget, checking busy in every RUN cycle. If pulse_at
    // is >= 0, a start with alternative operands is pulsed in that RUN cycle.
    task automatic run_and_wait(input string name, input int pulse_at,
                                input logic [W-1:0] alt_a, input logic [W-1:0] alt_b);
        int lat;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            chk({name, " busy"}, 32'(busy), 32'd1);
            if (lat == pulse_at) begin
                start = 1'b1;
                a     = alt_a;
                b     = alt_b;
                bin   = 1'b0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        chk({name, " latency"}, 32'(lat), 32'(NIB));
        chk({name, " busy at done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0};
        vecs[1] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0};
        vecs[2] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h0006, 16'h0005, 1'b1, 16'h0000, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
        vecs[6] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
        vecs[8] = '{16'h1234, 16'hABCD, 1'b0, 16'h6667, 1'b1};
        vecs[9] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0};

        // Reset with start also high: reset must win.
        rst   = 1'b1;
        start = 1'b1;
        a     = 16'hFFFF;
        b     = 16'h0001;
        bin   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset res",  32'(res),  32'd0);
        chk("reset bout", 32'(bout), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("idle busy", 32'(busy), 32'd0);

        // Table-driven operations, one idle cycle between each.
        for (int i = 0; i < 10; i++) begin
            a     = vecs[i].a;
            b     = vecs[i].b;
            bin   = vecs[i].bin;
            start = 1'b1;
            run_and_wait($sformatf("vec%0d", i), -1, '0, '0);
            chk($sformatf("vec%0d res", i),  32'(res),  32'(exp_res(vecs[i].res, vecs[i].bout)));
            chk($sformatf("vec%0d bout", i), 32'(bout), 32'(vecs[i].bout));
            @(negedge clk);
            chk($sformatf("vec%0d done pulse", i), 32'(done), 32'd0);
            chk($sformatf("vec%0d idle", i),       32'(busy), 32'd0);
        end

        // Start pulse during RUN with different operands is ignored.
        a = 16'h1234; b = 16'h0034; bin = 1'b0; start = 1'b1;
        run_and_wait("ignore", 1, 16'hFFFF, 16'h0001);
        chk("ignore res",  32'(res),  32'h1200);
        chk("ignore bout", 32'(bout), 32'd0);
        @(negedge clk);
        chk("ignore no restart busy", 32'(busy), 32'd0);
        chk("ignore no second done",  32'(done), 32'd0);

        // Back-to-back: second start asserted in the DONE cycle.
        a = 16'h8000; b = 16'h0001; bin = 1'b0; start = 1'b1;
        run_and_wait("b2b first", -1, '0, '0);
        chk("b2b first res",  32'(res),  32'h7FFF);
        chk("b2b first bout", 32'(bout), 32'd0);
        a = 16'h0005; b = 16'h0005; bin = 1'b1; start = 1'b1;
        run_and_wait("b2b second", -1, '0, '0);
        chk("b2b second res",  32'(res),  32'(exp_res(16'hFFFF, 1'b1)));
        chk("b2b second bout", 32'(bout), 32'd1);
        @(negedge clk);

        // Reset during the 2nd RUN cycle aborts the operation.
        a = 16'hABCD; b = 16'h1234; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort pre busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort res",  32'(res),  32'd0);
        chk("abort bout", 32'(bout), 32'd0);
        rst = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (done === 1'b1 || busy === 1'b1) seen++;
            end
            chk("abort no done", 32'(seen), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nibble_serial_sub.md
# nibble_serial_sub

Multi-cycle unsigned subtractor computing `res = a - b - bin` over a 4·NIBBLES-bit word, one 4-bit nibble per clock, LSB nibble first.

- Each nibble is evaluated as `a_n + ~b_n + c`, with carry `c` held in a register between nibbles.
- This is the sequencing stage in front of the team's 4-bit lookahead subtract slice: it latches wide operands, feeds the slice one nibble at a time, collects the nibble results, and reports the final borrow.
- A start/busy/done handshake connects it to the controlling logic.

## Interface

Reset is synchronous and active-high; the block uses one clock.

Parameters:
- `NIBBLES`, default 4: number of 4-bit nibbles. Word width `W = 4*NIBBLES`. Legal range is 1–16.

Ports:
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request a new subtraction. Sampled only when not busy.
- `a`, input, W: minuend. Latched on an accepted start.
- `b`, input, W: subtrahend. Latched on an accepted start.
- `bin`, input, 1: borrow-in. Latched on an accepted start.
- `busy`, output, 1: high while nibbles are being processed.
- `done`, output, 1: one-cycle pulse; result valid.
- `res`, output, W: difference, modulo 2^W.
- `bout`, output, 1: final borrow, i.e. `a < b + bin`.

## Operation

- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - `start=1` → latch `a`, `b`, and `c = ~bin`; clear nibble index `idx = 0`; go to RUN.
  - `start=0` → stay in IDLE.
- RUN, once per cycle:
  - Compute `{cn, s} = a[idx] + ~b[idx] + c` (4-bit slice).
  - Write `s` into `res` nibble `idx`, set `c ← cn`, increment `idx`.
  - After the nibble with `idx = NIBBLES-1`, set `bout ← ~cn` and go to DONE.
- DONE:
  - `done=1` for exactly this cycle.
  - `start=1` → accepted: latch new operands and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- `busy` is 1 exactly in RUN.
- `start` while in RUN is ignored. Operand inputs are don't-care outside the accepting cycle.
- `res` and `bout` hold their last values until the next accepted start.
  - During RUN, `res` nibbles update progressively and are not valid until `done`.
- Arithmetic is unsigned, with wrap-around modulo 2^W. No overflow flag.
- Reset mid-operation aborts immediately: next state is IDLE, and the partial result is discarded.

## Timing

- Reset values: `busy=0`, `done=0`, `res=0`, `bout=0`, `idx=0`, `c=0`, state IDLE.
- Let edge 0 be the edge that samples `start=1`:
  - `busy=1` after edges 0 through NIBBLES-1.
  - `done=1` after edge NIBBLES, for one cycle; `res` and `bout` are valid at the same time.
- Latency is NIBBLES+1 cycles from start to done. With NIBBLES=4, done appears 5 cycles after start.
- Throughput: a new start accepted in the DONE cycle gives one result every NIBBLES+1 cycles.
- `rst` has priority over `start` on the same edge.

## Configuration

- `NSUB_SATURATE_EN`:
  - Defined: when the final borrow is 1, `res` is forced to 0 in the DONE cycle (unsigned floor saturation); `bout` is still reported as 1.
  - Not defined: `res` is the raw modulo-2^W difference.

## Test plan

All scenarios use NIBBLES=4.

- **Basic subtraction:** `a=0x1234`, `b=0x0034`, `bin=0`, start pulse → `busy` high for 4 cycles, then `done` 5 cycles after start, with `res=0x1200`, `bout=0`.
- **Borrow ripple:** `a=0x8000`, `b=0x0001`, `bin=0` → `res=0x7FFF`, `bout=0`; the borrow propagates through all four nibbles.
- **Underflow:** `a=0x0000`, `b=0x0001`, `bin=0` → `res=0xFFFF`, `bout=1`. With `NSUB_SATURATE_EN` defined → `res=0x0000`, `bout=1`.
- **Borrow-in:** `a=0x0005`, `b=0x0005`, `bin=1` → `res=0xFFFF`, `bout=1`. Then `a=0x0006`, same `b`, `bin=1` → `res=0x0000`, `bout=0`.
- **Handshake:**
  - A start pulse during RUN, with different operands, is ignored; the first result is unchanged.
  - A start asserted in the DONE cycle is accepted, and the second done follows 5 cycles later.
- **Reset mid-operation:** `rst` asserted at the 2nd RUN cycle → next cycle has `busy=0`, `done=0`, `res=0`, `bout=0`. No `done` pulse ever appears for the aborted operation.
